// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX/MEM and (optional) MEM/WB operand forwarding and load-use detection.
// Define FWD_WB_EN to enable the MEM/WB forwarding path; by default only EX/MEM forwards.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [4:0]        id_shamt,
  input  logic [3:0]        id_alu_ctl,
  input  logic              id_sign,
  input  logic              id_alusrc1,
  input  logic              id_alusrc2,
  input  logic [3:0]        id_mem_ctl,
  input  logic              exm_regwrite,
  input  logic [REG_AW-1:0] exm_rd,
  input  logic [DATA_W-1:0] exm_result,
  input  logic              wb_regwrite,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] alu_in1,
  output logic [DATA_W-1:0] alu_in2,
  output logic [3:0]        alu_ctl,
  output logic              alu_sign,
  output logic              ex_valid,
  output logic [REG_AW-1:0] ex_rd,
  output logic [3:0]        ex_mem_ctl,
  output logic [DATA_W-1:0] ex_store_data,
  output logic              load_use
);

  logic              r_valid;
  logic [REG_AW-1:0] r_rs;
  logic [REG_AW-1:0] r_rt;
  logic [REG_AW-1:0] r_rd;
  logic [DATA_W-1:0] r_rs_data;
  logic [DATA_W-1:0] r_rt_data;
  logic [DATA_W-1:0] r_imm;
  logic [4:0]        r_shamt;
  logic [3:0]        r_alu_ctl;
  logic              r_sign;
  logic              r_alusrc1;
  logic              r_alusrc2;
  logic [3:0]        r_mem_ctl;

  logic [DATA_W-1:0] w_fwd_rs;
  logic [DATA_W-1:0] w_fwd_rt;

  // A bubble (flush or id_valid=0) clears the fields that could cause side effects downstream.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid   <= 1'b0;
      r_rs      <= '0;
      r_rt      <= '0;
      r_rd      <= '0;
      r_rs_data <= '0;
      r_rt_data <= '0;
      r_imm     <= '0;
      r_shamt   <= '0;
      r_alu_ctl <= '0;
      r_sign    <= 1'b0;
      r_alusrc1 <= 1'b0;
      r_alusrc2 <= 1'b0;
      r_mem_ctl <= '0;
    end else if (flush) begin
      r_valid   <= 1'b0;
      r_rd      <= '0;
      r_mem_ctl <= '0;
    end else if (!stall) begin
      r_valid   <= id_valid;
      r_rs      <= id_rs;
      r_rt      <= id_rt;
      r_rd      <= id_valid ? id_rd : '0;
      r_rs_data <= id_rs_data;
      r_rt_data <= id_rt_data;
      r_imm     <= id_imm;
      r_shamt   <= id_shamt;
      r_alu_ctl <= id_alu_ctl;
      r_sign    <= id_sign;
      r_alusrc1 <= id_alusrc1;
      r_alusrc2 <= id_alusrc2;
      r_mem_ctl <= id_valid ? id_mem_ctl : 4'b0000;
    end
  end

  // EX/MEM is the younger producer, so it takes precedence over MEM/WB.
  always_comb begin
    w_fwd_rs = r_rs_data;
    w_fwd_rt = r_rt_data;
    if (exm_regwrite && (exm_rd != '0) && (exm_rd == r_rs))
      w_fwd_rs = exm_result;
`ifdef FWD_WB_EN
    else if (wb_regwrite && (wb_rd != '0) && (wb_rd == r_rs))
      w_fwd_rs = wb_data;
`endif
    if (exm_regwrite && (exm_rd != '0) && (exm_rd == r_rt))
      w_fwd_rt = exm_result;
`ifdef FWD_WB_EN
    else if (wb_regwrite && (wb_rd != '0) && (wb_rd == r_rt))
      w_fwd_rt = wb_data;
`endif
  end

`ifndef FWD_WB_EN
  logic w_unused_wb;
  assign w_unused_wb = ^{wb_regwrite, wb_rd, wb_data};
`endif

  assign alu_in1       = r_alusrc1 ? {{(DATA_W-5){1'b0}}, r_shamt} : w_fwd_rs;
  assign alu_in2       = r_alusrc2 ? r_imm : w_fwd_rt;
  assign ex_store_data = w_fwd_rt;
  assign alu_ctl       = r_alu_ctl;
  assign alu_sign      = r_sign;
  assign ex_valid      = r_valid;
  assign ex_rd         = r_rd;
  assign ex_mem_ctl    = r_valid ? r_mem_ctl : 4'b0000;

  // mem_ctl bit 2 is memread; compared against the un-registered ID source indices.
  assign load_use = r_valid && r_mem_ctl[2] && (r_rd != '0) &&
                    ((r_rd == id_rs) || (r_rd == id_rt));

endmodule
